// File: rtl/raster_tri_sequencer_if.sv
// Triangle-in / rasterizer-control / pixel-out bundle for raster_tri_sequencer.
// Statistics counters appear only when RASTER_SEQ_STATS_EN is defined.
interface raster_tri_sequencer_if;
  logic        in_tri_valid;
  logic        out_tri_ready;
  logic [95:0] in_tri_xy;
  logic [5:0]  in_tri_depth;
  logic [47:0] in_tri_color;

  logic [95:0] out_r_xy;
  logic [5:0]  out_r_depth;
  logic [47:0] out_r_color;

  logic        out_sig_start_new_triangle;
  logic        out_sig_get_boundary_coords;
  logic        out_sig_form_edges;
  logic        out_sig_pixel_loop_setup;
  logic        out_sig_rasterize_pixels;
  logic        in_sig_rasterize_write_pixel;
  logic        in_sig_rasterize_done;

  logic [15:0] in_pix_x;
  logic [15:0] in_pix_y;
  logic [1:0]  in_pix_depth;
  logic [15:0] in_pix_color;

  logic        out_pix_valid;
  logic        in_pix_ready;
  logic [15:0] out_pix_x;
  logic [15:0] out_pix_y;
  logic [1:0]  out_pix_depth;
  logic [15:0] out_pix_color;

  logic        out_busy;
  logic        out_tri_done;
  logic        out_error;

`ifdef RASTER_SEQ_STATS_EN
  logic [15:0] out_stat_tris;
  logic [31:0] out_stat_pixels;
  logic [31:0] out_stat_stall;

  modport master (
    output in_tri_valid, in_tri_xy, in_tri_depth, in_tri_color,
    output in_sig_rasterize_write_pixel, in_sig_rasterize_done,
    output in_pix_x, in_pix_y, in_pix_depth, in_pix_color, in_pix_ready,
    input  out_tri_ready, out_r_xy, out_r_depth, out_r_color,
    input  out_sig_start_new_triangle, out_sig_get_boundary_coords,
    input  out_sig_form_edges, out_sig_pixel_loop_setup, out_sig_rasterize_pixels,
    input  out_pix_valid, out_pix_x, out_pix_y, out_pix_depth, out_pix_color,
    input  out_busy, out_tri_done, out_error,
    input  out_stat_tris, out_stat_pixels, out_stat_stall
  );

  modport slave (
    input  in_tri_valid, in_tri_xy, in_tri_depth, in_tri_color,
    input  in_sig_rasterize_write_pixel, in_sig_rasterize_done,
    input  in_pix_x, in_pix_y, in_pix_depth, in_pix_color, in_pix_ready,
    output out_tri_ready, out_r_xy, out_r_depth, out_r_color,
    output out_sig_start_new_triangle, out_sig_get_boundary_coords,
    output out_sig_form_edges, out_sig_pixel_loop_setup, out_sig_rasterize_pixels,
    output out_pix_valid, out_pix_x, out_pix_y, out_pix_depth, out_pix_color,
    output out_busy, out_tri_done, out_error,
    output out_stat_tris, out_stat_pixels, out_stat_stall
  );
`else
  modport master (
    output in_tri_valid, in_tri_xy, in_tri_depth, in_tri_color,
    output in_sig_rasterize_write_pixel, in_sig_rasterize_done,
    output in_pix_x, in_pix_y, in_pix_depth, in_pix_color, in_pix_ready,
    input  out_tri_ready, out_r_xy, out_r_depth, out_r_color,
    input  out_sig_start_new_triangle, out_sig_get_boundary_coords,
    input  out_sig_form_edges, out_sig_pixel_loop_setup, out_sig_rasterize_pixels,
    input  out_pix_valid, out_pix_x, out_pix_y, out_pix_depth, out_pix_color,
    input  out_busy, out_tri_done, out_error
  );

  modport slave (
    input  in_tri_valid, in_tri_xy, in_tri_depth, in_tri_color,
    input  in_sig_rasterize_write_pixel, in_sig_rasterize_done,
    input  in_pix_x, in_pix_y, in_pix_depth, in_pix_color, in_pix_ready,
    output out_tri_ready, out_r_xy, out_r_depth, out_r_color,
    output out_sig_start_new_triangle, out_sig_get_boundary_coords,
    output out_sig_form_edges, out_sig_pixel_loop_setup, out_sig_rasterize_pixels,
    output out_pix_valid, out_pix_x, out_pix_y, out_pix_depth, out_pix_color,
    output out_busy, out_tri_done, out_error
  );
`endif
endinterface

// File: rtl/raster_tri_sequencer.sv
// Per-triangle phase sequencer for the edge rasterizer with pixel forwarding and watchdog.
// Define RASTER_SEQ_STATS_EN to add saturating triangle/pixel/stall counters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | ready for a triangle; latch vertex data on valid
// S_START    | start_new_triangle held for PHASE_CYCLES
// S_BOUNDS   | get_boundary_coords held for PHASE_CYCLES
// S_EDGES    | form_edges held for PHASE_CYCLES
// S_LOOPSET  | pixel_loop_setup held for PHASE_CYCLES
// S_RASTER   | rasterize gated by framebuffer ready, watchdog running
// S_FINISH   | one-cycle tri_done pulse, back to idle
module raster_tri_sequencer #(
  parameter int PHASE_CYCLES = 1,
  parameter int TIMEOUT      = 65535
) (
  input logic                   clock,
  input logic                   reset,
  raster_tri_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BOUNDS,
    S_EDGES,
    S_LOOPSET,
    S_RASTER,
    S_FINISH
  } state_t;

  localparam logic [3:0]  PHASE_LOAD = 4'(PHASE_CYCLES - 1);
  localparam logic [15:0] WD_LOAD    = 16'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  phase_cnt;
  logic [15:0] wd_cnt;
  logic        phase_tc;
  logic        raster_en;
  logic        pix_valid;

  logic        tri_ready_q;
  logic        busy_q;
  logic        tri_done_q;
  logic        error_q;
  logic        sig_start_q;
  logic        sig_bounds_q;
  logic        sig_edges_q;
  logic        sig_loopset_q;
  logic [95:0] r_xy_q;
  logic [5:0]  r_depth_q;
  logic [47:0] r_color_q;

  assign phase_tc = (phase_cnt == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      phase_cnt     <= 4'd0;
      wd_cnt        <= 16'd0;
      raster_en     <= 1'b0;
      tri_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      tri_done_q    <= 1'b0;
      error_q       <= 1'b0;
      sig_start_q   <= 1'b0;
      sig_bounds_q  <= 1'b0;
      sig_edges_q   <= 1'b0;
      sig_loopset_q <= 1'b0;
      r_xy_q        <= 96'd0;
      r_depth_q     <= 6'd0;
      r_color_q     <= 48'd0;
    end else begin
      tri_done_q <= 1'b0;
      error_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_tri_valid) begin
            r_xy_q      <= bus.in_tri_xy;
            r_depth_q   <= bus.in_tri_depth;
            r_color_q   <= bus.in_tri_color;
            state       <= S_START;
            phase_cnt   <= PHASE_LOAD;
            sig_start_q <= 1'b1;
            tri_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        S_START: begin
          if (phase_tc) begin
            state        <= S_BOUNDS;
            phase_cnt    <= PHASE_LOAD;
            sig_start_q  <= 1'b0;
            sig_bounds_q <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        S_BOUNDS: begin
          if (phase_tc) begin
            state        <= S_EDGES;
            phase_cnt    <= PHASE_LOAD;
            sig_bounds_q <= 1'b0;
            sig_edges_q  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        S_EDGES: begin
          if (phase_tc) begin
            state         <= S_LOOPSET;
            phase_cnt     <= PHASE_LOAD;
            sig_edges_q   <= 1'b0;
            sig_loopset_q <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        S_LOOPSET: begin
          if (phase_tc) begin
            state         <= S_RASTER;
            sig_loopset_q <= 1'b0;
            raster_en     <= 1'b1;
            wd_cnt        <= WD_LOAD;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        S_RASTER: begin
          // done is checked first so it wins over a watchdog expiry in the same cycle
          if (bus.in_sig_rasterize_done) begin
            state      <= S_FINISH;
            raster_en  <= 1'b0;
            tri_done_q <= 1'b1;
          end else if (wd_cnt == 16'd0) begin
            state       <= S_IDLE;
            raster_en   <= 1'b0;
            error_q     <= 1'b1;
            tri_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt - 16'd1;
          end
        end
        S_FINISH: begin
          state       <= S_IDLE;
          tri_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          raster_en   <= 1'b0;
          tri_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pix_valid = raster_en & bus.in_sig_rasterize_write_pixel & bus.in_pix_ready;

  assign bus.out_tri_ready               = tri_ready_q;
  assign bus.out_busy                    = busy_q;
  assign bus.out_tri_done                = tri_done_q;
  assign bus.out_error                   = error_q;
  assign bus.out_r_xy                    = r_xy_q;
  assign bus.out_r_depth                 = r_depth_q;
  assign bus.out_r_color                 = r_color_q;
  assign bus.out_sig_start_new_triangle  = sig_start_q;
  assign bus.out_sig_get_boundary_coords = sig_bounds_q;
  assign bus.out_sig_form_edges          = sig_edges_q;
  assign bus.out_sig_pixel_loop_setup    = sig_loopset_q;
  // framebuffer backpressure freezes the rasterizer by dropping its advance strobe
  assign bus.out_sig_rasterize_pixels    = raster_en & bus.in_pix_ready;
  assign bus.out_pix_valid               = pix_valid;
  assign bus.out_pix_x                   = bus.in_pix_x;
  assign bus.out_pix_y                   = bus.in_pix_y;
  assign bus.out_pix_depth               = bus.in_pix_depth;
  assign bus.out_pix_color               = bus.in_pix_color;

`ifdef RASTER_SEQ_STATS_EN
  logic [15:0] stat_tris;
  logic [31:0] stat_pixels;
  logic [31:0] stat_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_tris   <= 16'd0;
      stat_pixels <= 32'd0;
      stat_stall  <= 32'd0;
    end else begin
      if (tri_done_q && (stat_tris != 16'hFFFF))
        stat_tris <= stat_tris + 16'd1;
      if (pix_valid && (stat_pixels != 32'hFFFF_FFFF))
        stat_pixels <= stat_pixels + 32'd1;
      if (raster_en && !bus.in_pix_ready && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end

  assign bus.out_stat_tris   = stat_tris;
  assign bus.out_stat_pixels = stat_pixels;
  assign bus.out_stat_stall  = stat_stall;
`endif

endmodule
